// File: rtl/dev_reshuffler_pkg.sv
// Shared reshuffler definitions: tile geometry and the tile type used by
// the gather stage and the reshuffler core.
package dev_reshuffler_pkg;

    localparam int SpatPar   = 8;                 // rows per tile, must be >= 2
    localparam int DataWidth = 64;                // bits per row
    localparam int RowIdxW   = $clog2(SpatPar);   // derived, not overridden
    localparam int TileCntW  = 16;                // emitted-tile counter width

    typedef logic [DataWidth-1:0]               row_t;
    typedef logic [RowIdxW-1:0]                 row_idx_t;
    typedef logic [SpatPar-1:0][DataWidth-1:0]  tile_t;

endpackage

// File: rtl/dev_reshuffler_gather_if.sv
// Bundle between a row streamer, the gather stage and the reshuffler input.
//
// Handshake: both channels are valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both high. Once tile_valid_o is high,
// it and tile_o hold until that transfer; the producer never lowers valid or
// changes data while waiting. row_last_i has meaning only alongside an
// accepted row.
interface dev_reshuffler_gather_if;
    import dev_reshuffler_pkg::*;

    row_t                 row_i;
    logic                 row_valid_i;
    logic                 row_last_i;
    logic                 row_ready_o;
    tile_t                tile_o;
    logic                 tile_valid_o;
    logic                 tile_ready_i;
    logic [TileCntW-1:0]  tile_cnt_o;

    // Upstream streamer plus downstream reshuffler side.
    modport master (
        output row_i, row_valid_i, row_last_i, tile_ready_i,
        input  row_ready_o, tile_o, tile_valid_o, tile_cnt_o
    );

    // Gather stage side.
    modport slave (
        input  row_i, row_valid_i, row_last_i, tile_ready_i,
        output row_ready_o, tile_o, tile_valid_o, tile_cnt_o
    );

endinterface

// File: rtl/dev_gather_tile_buf.sv
// One tile register: writes a single row slot per cycle, or clears the
// whole tile. Clear wins, so a popped buffer always restarts at zero.
module dev_gather_tile_buf
    import dev_reshuffler_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     wr_en_i,
    input  row_idx_t wr_idx_i,
    input  row_t     row_i,
    input  logic     clr_i,
    output tile_t    tile_o
);

    tile_t tile_q;

    // Tile storage: reset/clear to zero, otherwise write the addressed row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tile_q <= '0;
        end else if (clr_i) begin
            tile_q <= '0;
        end else if (wr_en_i) begin
            tile_q[wr_idx_i] <= row_i;
        end
    end

    assign tile_o = tile_q;

endmodule

// File: rtl/dev_reshuffler_gather.sv
// Gather stage: packs SpatPar rows into a tile using two ping-pong buffers
// so one tile can fill while the previous one waits on the reshuffler.
module dev_reshuffler_gather
    import dev_reshuffler_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    dev_reshuffler_gather_if.slave  bus
);

    logic                wr_sel_q, wr_sel_d;
    logic                rd_sel_q, rd_sel_d;
    row_idx_t            row_idx_q, row_idx_d;
    logic [1:0]          full_cnt_q, full_cnt_d;
    logic [TileCntW-1:0] tile_cnt_q, tile_cnt_d;

    logic  row_ready;
    logic  tile_valid;
    logic  accept;
    logic  close;
    logic  pop;
    tile_t buf_tile [2];

    // Ready and valid come only from full_cnt, never from the other side's
    // handshake inputs, so there is no combinational path through the block.
    assign row_ready  = (full_cnt_q < 2'd2);
    assign tile_valid = (full_cnt_q != 2'd0);

    assign accept = bus.row_valid_i && row_ready;
    assign close  = accept &&
                    ((row_idx_q == row_idx_t'(SpatPar - 1)) || bus.row_last_i);
    assign pop    = tile_valid && bus.tile_ready_i;

    // Write and clear never hit the same buffer: when both pointers are equal
    // either nothing is full (no pop) or both are full (no accept).
    for (genvar i = 0; i < 2; i++) begin : g_buf
        dev_gather_tile_buf u_buf (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .wr_en_i  (accept && (wr_sel_q == 1'(i))),
            .wr_idx_i (row_idx_q),
            .row_i    (bus.row_i),
            .clr_i    (pop && (rd_sel_q == 1'(i))),
            .tile_o   (buf_tile[i])
        );
    end

    // Next-state: pointers, slot index, occupancy and the tile counter.
    always_comb begin
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        row_idx_d  = row_idx_q;
        full_cnt_d = full_cnt_q;
        tile_cnt_d = tile_cnt_q;

        if (accept) begin
            if (close) begin
                row_idx_d = '0;
                wr_sel_d  = ~wr_sel_q;
            end else begin
                row_idx_d = row_idx_q + row_idx_t'(1);
            end
        end

        if (pop) begin
            rd_sel_d   = ~rd_sel_q;
            tile_cnt_d = tile_cnt_q + TileCntW'(1);
        end

        unique case ({close, pop})
            2'b10:   full_cnt_d = full_cnt_q + 2'd1;
            2'b01:   full_cnt_d = full_cnt_q - 2'd1;
            default: full_cnt_d = full_cnt_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            row_idx_q  <= '0;
            full_cnt_q <= 2'd0;
            tile_cnt_q <= '0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            row_idx_q  <= row_idx_d;
            full_cnt_q <= full_cnt_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    // With nothing full, rd_sel points at the buffer being filled; mask it so
    // an idle output shows zero rather than a partial tile.
    assign bus.tile_o       = tile_valid ? buf_tile[rd_sel_q] : '0;
    assign bus.tile_valid_o = tile_valid;
    assign bus.row_ready_o  = row_ready;
    assign bus.tile_cnt_o   = tile_cnt_q;

endmodule

// File: tb/tb_dev_reshuffler_gather.sv
// Directed bench for the gather stage: fill, early close, back-pressure,
// close-with-pop, reset mid-tile, last on the final slot and counter wrap.
module tb_dev_reshuffler_gather;
    import dev_reshuffler_pkg::*;

    logic clk_i;
    logic rst_ni;

    dev_reshuffler_gather_if bus ();

    dev_reshuffler_gather dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [511:0] exp_q[$];

    // Clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] make_tile(input logic [63:0] base,
                                               input int nrows);
        logic [511:0] t;
        t = '0;
        for (int r = 0; r < 8; r++)
            if (r < nrows) t[r*64 +: 64] = base + 64'(r);
        return t;
    endfunction

    // Drive one row and wait (bounded) until it is accepted; returns on the
    // falling edge after the accepting rising edge.
    task automatic push_row(input logic [63:0] d, input logic last);
        int n;
        n = 0;
        bus.row_i       = d;
        bus.row_valid_i = 1'b1;
        bus.row_last_i  = last;
        while (!bus.row_ready_o && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        if (!bus.row_ready_o) begin
            check("push_timeout", 1'b0, 1'b1);
        end else begin
            @(negedge clk_i);
        end
        bus.row_valid_i = 1'b0;
        bus.row_last_i  = 1'b0;
    endtask

    // Compare the presented tile with the scoreboard head, then pop it.
    task automatic pop_check(input string tag);
        logic [511:0] exp_tile;
        exp_tile = '0;
        if (exp_q.size() == 0) begin
            check({tag, "_empty_q"}, 1'b1, 1'b0);
        end else begin
            exp_tile = exp_q.pop_front();
        end
        check({tag, "_valid"}, bus.tile_valid_o, 1'b1);
        check({tag, "_tile"}, bus.tile_o, exp_tile);
        bus.tile_ready_i = 1'b1;
        @(negedge clk_i);
        bus.tile_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        int n;
        int guard;

        bus.row_i        = '0;
        bus.row_valid_i  = 1'b0;
        bus.row_last_i   = 1'b0;
        bus.tile_ready_i = 1'b0;
        rst_ni           = 1'b0;
        @(negedge clk_i);
        do_reset();

        // Reset values.
        check("rst_row_ready", bus.row_ready_o, 1'b1);
        check("rst_tile_valid", bus.tile_valid_o, 1'b0);
        check("rst_tile", bus.tile_o, '0);
        check("rst_tile_cnt", bus.tile_cnt_o, 16'd0);

        // Basic fill with the reshuffler always ready.
        bus.tile_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) push_row(64'(i), 1'b0);
        check("basic_valid", bus.tile_valid_o, 1'b1);
        check("basic_tile", bus.tile_o, make_tile(64'h0, 8));
        @(negedge clk_i);
        bus.tile_ready_i = 1'b0;
        check("basic_cnt", bus.tile_cnt_o, 16'd1);
        check("basic_valid_after", bus.tile_valid_o, 1'b0);
        check("basic_tile_after", bus.tile_o, '0);

        // Early close after three rows.
        push_row(64'hA, 1'b0);
        push_row(64'hB, 1'b0);
        push_row(64'hC, 1'b1);
        exp_q.push_back(make_tile(64'hA, 3));
        check("early_ready", bus.row_ready_o, 1'b1);
        pop_check("early");
        check("early_cnt", bus.tile_cnt_o, 16'd2);
        check("early_valid_after", bus.tile_valid_o, 1'b0);

        // Back-pressure: both buffers fill, then one pop frees a slot.
        for (int i = 0; i < 16; i++) push_row(64'h100 + 64'(i), 1'b0);
        exp_q.push_back(make_tile(64'h100, 8));
        exp_q.push_back(make_tile(64'h108, 8));
        check("bp_ready_low", bus.row_ready_o, 1'b0);
        check("bp_tile_first", bus.tile_o, exp_q[0]);
        bus.row_i       = 64'h110;
        bus.row_valid_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("bp_tile_stable", bus.tile_o, exp_q[0]);
        check("bp_ready_still_low", bus.row_ready_o, 1'b0);
        pop_check("bp_t0");
        check("bp_ready_back", bus.row_ready_o, 1'b1);
        for (int i = 0; i < 8; i++) push_row(64'h110 + 64'(i), 1'b0);
        exp_q.push_back(make_tile(64'h110, 8));
        pop_check("bp_t1");
        pop_check("bp_t2");
        check("bp_valid_after", bus.tile_valid_o, 1'b0);
        check("bp_cnt", bus.tile_cnt_o, 16'd5);

        // Close of the next tile in the same cycle as the pop of the waiting one.
        for (int i = 0; i < 8; i++) push_row(64'h200 + 64'(i), 1'b0);
        exp_q.push_back(make_tile(64'h200, 8));
        for (int i = 0; i < 7; i++) push_row(64'h300 + 64'(i), 1'b0);
        bus.row_i        = 64'h307;
        bus.row_valid_i  = 1'b1;
        bus.row_last_i   = 1'b0;
        bus.tile_ready_i = 1'b1;
        check("sim_ready_pre", bus.row_ready_o, 1'b1);
        check("sim_t3_tile", bus.tile_o, exp_q.pop_front());
        @(negedge clk_i);
        bus.row_valid_i  = 1'b0;
        bus.tile_ready_i = 1'b0;
        exp_q.push_back(make_tile(64'h300, 8));
        check("sim_cnt", bus.tile_cnt_o, 16'd6);
        check("sim_ready_post", bus.row_ready_o, 1'b1);
        pop_check("sim_t4");
        check("sim_valid_after", bus.tile_valid_o, 1'b0);
        check("sim_cnt_after", bus.tile_cnt_o, 16'd7);

        // Reset with one full tile pending and five rows of a partial one.
        for (int i = 0; i < 8; i++) push_row(64'h400 + 64'(i), 1'b0);
        for (int i = 0; i < 5; i++) push_row(64'h500 + 64'(i), 1'b0);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_row_ready", bus.row_ready_o, 1'b1);
        check("mid_rst_tile_valid", bus.tile_valid_o, 1'b0);
        check("mid_rst_tile", bus.tile_o, '0);
        check("mid_rst_tile_cnt", bus.tile_cnt_o, 16'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        push_row(64'h600, 1'b1);
        exp_q.push_back(make_tile(64'h600, 1));
        pop_check("post_rst_short");
        for (int i = 0; i < 8; i++) push_row(64'h680 + 64'(i), 1'b0);
        exp_q.push_back(make_tile(64'h680, 8));
        pop_check("post_rst_full");
        check("post_rst_cnt", bus.tile_cnt_o, 16'd2);

        // row_last on the final slot closes once; the following row starts anew.
        for (int i = 0; i < 8; i++) push_row(64'h700 + 64'(i), (i == 7));
        push_row(64'h800, 1'b1);
        exp_q.push_back(make_tile(64'h700, 8));
        exp_q.push_back(make_tile(64'h800, 1));
        pop_check("last7_a");
        pop_check("last7_b");
        check("last7_cnt", bus.tile_cnt_o, 16'd4);

        // Counter wrap: 65537 single-row tiles from a fresh reset.
        do_reset();
        bus.tile_ready_i = 1'b1;
        bus.row_i        = 64'h77;
        bus.row_valid_i  = 1'b1;
        bus.row_last_i   = 1'b1;
        n     = 0;
        guard = 0;
        while (n < 65537 && guard < 70000) begin
            if (bus.row_ready_o) n++;
            @(negedge clk_i);
            guard++;
        end
        bus.row_valid_i = 1'b0;
        bus.row_last_i  = 1'b0;
        check("wrap_accepts", n, 65537);
        repeat (2) @(negedge clk_i);
        bus.tile_ready_i = 1'b0;
        check("wrap_cnt", bus.tile_cnt_o, 16'd1);
        check("wrap_valid", bus.tile_valid_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dev_reshuffler_gather.md
# dev_reshuffler_gather

Upstream stage of the data reshuffler. It accepts one DataWidth-wide row per beat from a streamer port and assembles SpatPar consecutive rows into one SpatPar*DataWidth tile. Completed tiles are presented on a valid/ready output that feeds the reshuffler's `a_*` input. Two tile buffers (ping-pong) allow one tile to fill while the previous tile waits on the reshuffler.

## Interface
- SpatPar, 8: rows per tile; must be ≥2.
- DataWidth, 64: bits per row.
- RowIdxW, $clog2(SpatPar): row counter width; derived, not overridden.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- row_i  in  DataWidth  input row data.
- row_valid_i  in  1  input row valid.
- row_last_i  in  1  closes the current tile early; sampled only with an accepted row.
- row_ready_o  out  1  input ready.
- tile_o  out  SpatPar*DataWidth  assembled tile; row r at bits [r*DataWidth +: DataWidth].
- tile_valid_o  out  1  tile valid.
- tile_ready_i  in  1  tile ready from the reshuffler.
- tile_cnt_o  out  16  count of tiles emitted; wraps at 2^16.

## Operation
- State: buffers buf[0..1]; `wr_sel` (buffer being filled); `rd_sel` (oldest full buffer); `row_idx` (next row slot); `full_cnt` (0..2, number of full buffers).
- Row accepted when `row_valid_i && row_ready_o`:
  - The row is written to buf[wr_sel] at slot `row_idx`.
- A tile is closed when the accepted row has `row_idx == SpatPar-1` or `row_last_i == 1`. On close:
  - `row_idx` returns to 0.
  - `wr_sel` toggles.
  - `full_cnt` increments.
- If no tile is closed, `row_idx` increments.
- Early close: rows above the last written slot read as zero. Every buffer is cleared to all-zero when it is popped. Reset also clears both buffers.
- `row_last_i` on slot SpatPar-1 has the same effect as a normal close.
- `row_ready_o = (full_cnt < 2)`. The buffer being filled is never full.
- `tile_valid_o = (full_cnt != 0)`.
- `tile_o = buf[rd_sel]`.
  - When `tile_valid_o` is 0, `tile_o` shows the cleared (zero) buffer.
- Pop when `tile_valid_o && tile_ready_i`. On pop:
  - `rd_sel` toggles.
  - buf[rd_sel] is cleared.
  - `full_cnt` decrements.
  - `tile_cnt_o` increments (wraps from 0xFFFF to 0).
- Close and pop in the same cycle: `full_cnt` is unchanged, and both pointers toggle.
  - The clear targets buf[rd_sel] and the write targets buf[wr_sel]. These are always different buffers when `full_cnt ≥ 1` and a fill is in progress, so there is no conflict.
- Output handshake (AXI-stream style):
  - Once `tile_valid_o` is high, it and `tile_o` stay stable until a pop.
  - `tile_valid_o` never depends combinationally on `tile_ready_i`.
  - `row_ready_o` depends only on registered state.

## Timing
- Reset values: `row_ready_o` = 1, `tile_valid_o` = 0, `tile_o` = 0, `tile_cnt_o` = 0. Internal reset state: `wr_sel` = `rd_sel` = 0, `row_idx` = 0, `full_cnt` = 0.
- Latency: `tile_valid_o` rises the cycle after the closing row is accepted.
- Throughput: one row per cycle sustained when `tile_ready_i` pops each tile within SpatPar cycles of its close.
- Both full (`full_cnt == 2`): `row_ready_o` is low. It returns high the cycle after a pop.
  - No same-cycle pass-through: a pop in cycle N does not allow a row in cycle N.
- Reset mid-tile: the partial tile and both buffers are discarded, and all state returns to reset values.
- Back-to-back tiles: tile k+1 may close while tile k is still waiting on the output.

## Structure
- Shared package `dev_reshuffler_pkg`: localparams SpatPar and DataWidth, plus `typedef logic [SpatPar-1:0][DataWidth-1:0] tile_t`. The reshuffler and this block share these.
- Sub-module `dev_gather_tile_buf`: one tile register with `row write enable + index` and `clear` inputs, instantiated twice.
- Top level holds the pointers, `full_cnt`, `row_idx`, handshake logic and the tile counter.

## Test plan
Use SpatPar = 8, DataWidth = 64 for all scenarios.
- Basic fill: rows 0x00..0x07 with `tile_ready_i` = 1.
  - One cycle after row 0x07 is accepted: `tile_valid_o` = 1 and row r of `tile_o` holds r.
  - Popped that cycle; `tile_cnt_o` = 1.
- Early close: rows 0xA, 0xB, 0xC with `row_last_i` on 0xC.
  - Tile has rows 0..2 = A, B, C and rows 3..7 = 0.
- Back-pressure: `tile_ready_i` = 0 while streaming 24 rows.
  - After 16 rows, `row_ready_o` = 0 and `tile_o` is stable.
  - Then raise `tile_ready_i` for 1 cycle: `row_ready_o` returns next cycle, and the tiles emerge in order.
- Simultaneous close and pop: a tile is waiting, the next tile's 8th row arrives in the same cycle as `tile_ready_i` = 1.
  - `full_cnt` stays 1, and the second tile appears the next cycle unchanged.
- Reset mid-operation: assert `rst_ni` low after 5 rows with one full tile pending.
  - All outputs return to reset values.
  - A fresh 8-row stream produces a correct tile, and `tile_cnt_o` = 1 after its pop.
- Counter wrap: pop 65537 tiles (each an early close after 1 row) → `tile_cnt_o` = 1.
